// File: rtl/pipeline_pkg.sv
// Shared definitions for the 16-bit, 8-register pipeline: forwarding selects,
// register-zero constant and the decoded-control bundle carried between stages.
package pipeline_pkg;

  localparam int ALUOP_W  = 3;
  localparam int REG_ZERO = 0;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_WB      = 2'b01,
    FWD_MEM     = 2'b10
  } fwd_sel_t;

  // Control bundle shared by the ID/EX, EX/MEM and MEM/WB registers.
  typedef struct packed {
    logic               reg_dst;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_write;
    logic               valid;
  } ctrl_t;

endpackage

// File: rtl/forward_unit.sv
// Combinational EX-stage operand forwarding select; the nearer writer (MEM)
// beats the older one (WB), and register zero is never forwarded.
module forward_unit
  import pipeline_pkg::*;
#(
  parameter int REG_W = 3
) (
  input  logic             Mem_RegWrite,
  input  logic [REG_W-1:0] Mem_DestReg,
  input  logic             WB_RegWrite,
  input  logic [REG_W-1:0] WB_DestReg,
  input  logic [REG_W-1:0] EX_Rs,
  input  logic [REG_W-1:0] EX_Rt,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB
);

  logic w_mem_live;
  logic w_wb_live;

  assign w_mem_live = Mem_RegWrite && (Mem_DestReg != REG_W'(REG_ZERO));
  assign w_wb_live  = WB_RegWrite  && (WB_DestReg  != REG_W'(REG_ZERO));

  function automatic fwd_sel_t select_src(input logic [REG_W-1:0] src);
    if (w_mem_live && (Mem_DestReg == src)) return FWD_MEM;
    if (w_wb_live  && (WB_DestReg  == src)) return FWD_WB;
    return FWD_REGFILE;
  endfunction

  // NOTE: every output of an always_comb gets a default first so no latch is inferred.
  always_comb begin
    ForwardA = FWD_REGFILE;
    ForwardB = FWD_REGFILE;
    ForwardA = select_src(EX_Rs);
    ForwardB = select_src(EX_Rt);
  end

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use stall detection, bubble insertion on
// stall/flush, EX forwarding selects and saturating stall/flush counters.
module id_ex_hazard_reg
  import pipeline_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               ID_RegDst,
  input  logic               ID_ALUSrc,
  input  logic               ID_MemRead,
  input  logic               ID_MemWrite,
  input  logic               ID_MemToReg,
  input  logic               ID_RegWrite,
  input  logic               ID_Valid,
  input  logic [ALUOP_W-1:0] ID_ALUOp,
  input  logic [DATA_W-1:0]  ID_ReadData1,
  input  logic [DATA_W-1:0]  ID_ReadData2,
  input  logic [DATA_W-1:0]  ID_Imm,
  input  logic [REG_W-1:0]   ID_Rs,
  input  logic [REG_W-1:0]   ID_Rt,
  input  logic [REG_W-1:0]   ID_Rd,
  input  logic               Flush,
  input  logic               Mem_RegWrite,
  input  logic [REG_W-1:0]   Mem_DestReg,
  input  logic               WB_RegWrite,
  input  logic [REG_W-1:0]   WB_DestReg,
  output logic               EX_RegDst,
  output logic               EX_ALUSrc,
  output logic               EX_MemRead,
  output logic               EX_MemWrite,
  output logic               EX_MemToReg,
  output logic               EX_RegWrite,
  output logic               EX_Valid,
  output logic [ALUOP_W-1:0] EX_ALUOp,
  output logic [DATA_W-1:0]  EX_ReadData1,
  output logic [DATA_W-1:0]  EX_ReadData2,
  output logic [DATA_W-1:0]  EX_Imm,
  output logic [REG_W-1:0]   EX_Rs,
  output logic [REG_W-1:0]   EX_Rt,
  output logic [REG_W-1:0]   EX_Rd,
  output logic               Stall,
  output logic [1:0]         ForwardA,
  output logic [1:0]         ForwardB,
  output logic [CNT_W-1:0]   StallCount,
  output logic [CNT_W-1:0]   FlushCount
);

  ctrl_t              w_id_ctrl;
  ctrl_t              r_ctrl;
  logic [DATA_W-1:0]  r_rd1;
  logic [DATA_W-1:0]  r_rd2;
  logic [DATA_W-1:0]  r_imm;
  logic [REG_W-1:0]   r_rs;
  logic [REG_W-1:0]   r_rt;
  logic [REG_W-1:0]   r_rd;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic [CNT_W-1:0]   r_flush_cnt;
  logic               w_stall;

  assign w_id_ctrl = '{
    reg_dst:    ID_RegDst,
    alu_src:    ID_ALUSrc,
    alu_op:     ID_ALUOp,
    mem_read:   ID_MemRead,
    mem_write:  ID_MemWrite,
    mem_to_reg: ID_MemToReg,
    reg_write:  ID_RegWrite,
    valid:      ID_Valid
  };

  // Both ID specifiers are compared whether or not the instruction reads them.
  assign w_stall = !Flush && r_ctrl.mem_read && r_ctrl.valid &&
                   (r_rt != REG_W'(REG_ZERO)) &&
                   ((r_rt == ID_Rs) || (r_rt == ID_Rt));

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge Clk) begin
    if (Reset || Flush || w_stall) begin
      r_ctrl <= '0;
      r_rd1  <= '0;
      r_rd2  <= '0;
      r_imm  <= '0;
      r_rs   <= '0;
      r_rt   <= '0;
      r_rd   <= '0;
    end else begin
      r_ctrl <= w_id_ctrl;
      r_rd1  <= ID_ReadData1;
      r_rd2  <= ID_ReadData2;
      r_imm  <= ID_Imm;
      r_rs   <= ID_Rs;
      r_rt   <= ID_Rt;
      r_rd   <= ID_Rd;
    end
  end

  // Event counters stick at all-ones so a long run never reads as a small count.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (Flush && (r_flush_cnt != '1))   r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  forward_unit #(
    .REG_W (REG_W)
  ) u_forward_unit (
    .Mem_RegWrite (Mem_RegWrite),
    .Mem_DestReg  (Mem_DestReg),
    .WB_RegWrite  (WB_RegWrite),
    .WB_DestReg   (WB_DestReg),
    .EX_Rs        (r_rs),
    .EX_Rt        (r_rt),
    .ForwardA     (ForwardA),
    .ForwardB     (ForwardB)
  );

  assign EX_RegDst    = r_ctrl.reg_dst;
  assign EX_ALUSrc    = r_ctrl.alu_src;
  assign EX_MemRead   = r_ctrl.mem_read;
  assign EX_MemWrite  = r_ctrl.mem_write;
  assign EX_MemToReg  = r_ctrl.mem_to_reg;
  assign EX_RegWrite  = r_ctrl.reg_write;
  assign EX_Valid     = r_ctrl.valid;
  assign EX_ALUOp     = r_ctrl.alu_op;
  assign EX_ReadData1 = r_rd1;
  assign EX_ReadData2 = r_rd2;
  assign EX_Imm       = r_imm;
  assign EX_Rs        = r_rs;
  assign EX_Rt        = r_rt;
  assign EX_Rd        = r_rd;
  assign Stall        = w_stall;
  assign StallCount   = r_stall_cnt;
  assign FlushCount   = r_flush_cnt;

endmodule
